// File: rtl/nash_step_controller.sv
// nash_step_controller: sequences one NASH neuron timestep (integrate events, sample, fire).
// Owns the neuron control word; every integrate word carries a fresh tag so it lands exactly once.
module nash_step_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [15:0] ev_weight,
    input  logic        ev_last,
    output logic [15:0] n_wspike,
    output logic [15:0] n_control,
    input  logic        n_spike,
    input  logic [30:0] n_vmem,
    output logic        busy,
    output logic        done,
    output logic        spike_out,
    output logic [30:0] vmem_out,
    output logic [15:0] step_cnt,
    output logic [15:0] spike_cnt
);
    typedef enum logic [2:0] {IDLE, CLR, INTEG, DRAIN, SETTLE, FIRE, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] tag, tag_nx;
    logic [15:0] ctrl_nx;
    logic accept;
    always_comb begin
        accept = (state == INTEG) & ev_valid & ev_ready;
        state_nx = state;
        case (state)
            IDLE:    state_nx = clear ? CLR : start ? INTEG : IDLE;
            CLR:     state_nx = IDLE;
            INTEG:   state_nx = (accept & ev_last) ? DRAIN : INTEG;
            DRAIN:   state_nx = SETTLE;
            SETTLE:  state_nx = FIRE;
            FIRE:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        tag_nx = (state == CLR) ? 8'd0 : accept ? tag + 8'd1 : tag;
        // The control word is registered, so it is built for the state being entered.
        ctrl_nx = (state_nx == CLR) ? 16'h0001 :
                  (state_nx == FIRE) ? 16'h0004 :
                  {tag_nx, accept ? 8'h02 : 8'h00};
        busy = !(state inside {IDLE, CLR});
        done = (state == DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tag       <= 8'd0;
            n_control <= 16'h0001;
            n_wspike  <= 16'd0;
            ev_ready  <= 1'b0;
            spike_out <= 1'b0;
            vmem_out  <= 31'd0;
            step_cnt  <= 16'd0;
            spike_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            tag       <= tag_nx;
            n_control <= ctrl_nx;
            ev_ready  <= (state_nx == INTEG);
            if (accept)
                n_wspike <= ev_weight;
            if (state == CLR) begin
                spike_out <= 1'b0;
                vmem_out  <= 31'd0;
                step_cnt  <= 16'd0;
                spike_cnt <= 16'd0;
            end
            if (state == SETTLE) begin
                spike_out <= n_spike;
                vmem_out  <= n_vmem;
                if (n_spike && spike_cnt != 16'hFFFF)
                    spike_cnt <= spike_cnt + 16'd1;
            end
            if (state == DONE)
                step_cnt <= step_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_nash_step_controller.sv
// tb_nash_step_controller: drives timesteps into the controller with a behavioural neuron attached.
module tb_nash_step_controller;
    logic clk = 0, rst = 1, start = 0, clear = 0, ev_valid = 0, ev_last = 0;
    logic [15:0] ev_weight = 0;
    logic ev_ready, busy, done, spike_out, n_spike;
    logic [15:0] n_wspike, n_control, step_cnt, spike_cnt;
    logic [30:0] n_vmem, vmem_out;
    logic [30:0] nv = 0;
    logic [7:0] ntag = 0;
    int tests = 0, fails = 0;
    logic [7:0] m_tag = 0;
    int carry = 0, m_steps = 0, m_spikes = 0;
    int wq[$];

    typedef struct {
        int n;
        int w[4];
        int vm;
        bit sp;
    } step_t;
    step_t tbl[4];

    nash_step_controller dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_weight(ev_weight), .ev_last(ev_last),
        .n_wspike(n_wspike), .n_control(n_control), .n_spike(n_spike), .n_vmem(n_vmem),
        .busy(busy), .done(done), .spike_out(spike_out), .vmem_out(vmem_out),
        .step_cnt(step_cnt), .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    // Neuron: integrates only on a tag change, spikes strictly above 200, fire resets at >= 200.
    assign n_vmem = nv;
    assign n_spike = nv > 31'd200;
    always @(posedge clk) begin
        if (n_control[0]) begin
            nv <= 0;
            ntag <= 0;
        end else if (n_control[1] && n_control[15:8] != ntag) begin
            nv <= nv + 31'(n_wspike);
            ntag <= n_control[15:8];
        end else if (n_control[2] && nv >= 31'd200)
            nv <= 0;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tag = 0;
        carry = 0;
        m_steps = 0;
        m_spikes = 0;
    endtask

    task automatic do_clear(input bit with_start);
        clear = 1;
        start = with_start;
        @(posedge clk); #1;
        clear = 0;
        start = 0;
        chk("clr_word", n_control, 16'h0001);
        chk("clr_busy", busy, 0);
        chk("clr_ready", ev_ready, 0);
        model_reset();
        @(posedge clk); #1;
        chk("clr_idle_word", n_control, 16'h0000);
        chk("clr_ready2", ev_ready, 0);
        chk("clr_step_cnt", step_cnt, 0);
        chk("clr_spike_cnt", spike_cnt, 0);
        chk("clr_vmem_out", vmem_out, 0);
        chk("clr_spike_out", spike_out, 0);
        chk("clr_neuron_v", nv, 0);
    endtask

    task automatic run_step(input bit gaps, input bit poke);
        int k, cyc, sum;
        bit acc;
        sum = carry;
        foreach (wq[i]) sum += wq[i];
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("ready_on", ev_ready, 1);
        chk("busy_on", busy, 1);
        k = 0;
        cyc = 0;
        while (k < wq.size() && cyc < 3000) begin
            ev_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ev_weight = 16'(wq[k]);
            ev_last = (k == wq.size() - 1);
            if (poke && cyc == 1) begin
                start = 1;
                clear = 1;
            end
            acc = ev_valid & ev_ready;
            @(posedge clk); #1;
            start = 0;
            clear = 0;
            cyc++;
            if (acc) begin
                m_tag++;
                chk("integ_word", n_control, {m_tag, 8'h02});
                chk("wspike", n_wspike, 64'(wq[k]));
                k++;
            end else
                chk("hold_word", n_control, {m_tag, 8'h00});
        end
        if (k < wq.size()) chk("event_timeout", k, wq.size());
        ev_valid = 0;
        ev_last = 0;
        chk("drain_ready", ev_ready, 0);
        chk("drain_busy", busy, 1);
        @(posedge clk); #1;
        chk("settle_word", n_control, {m_tag, 8'h00});
        @(posedge clk); #1;
        chk("fire_word", n_control, 16'h0004);
        chk("vmem_out", vmem_out, 64'(sum));
        chk("spike_out", spike_out, sum > 200);
        @(posedge clk); #1;
        chk("done", done, 1);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        m_steps = (m_steps + 1) & 16'hFFFF;
        if (sum > 200 && m_spikes < 65535) m_spikes++;
        carry = (sum >= 200) ? 0 : sum;
        chk("step_cnt", step_cnt, 64'(m_steps));
        chk("spike_cnt", spike_cnt, 64'(m_spikes));
        chk("neuron_v", nv, 64'(carry));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3, '{50, 60, 100, 0}, 210, 1'b1};
        tbl[1] = '{2, '{120, 80, 0, 0}, 200, 1'b0};
        tbl[2] = '{1, '{100, 0, 0, 0}, 100, 1'b0};
        tbl[3] = '{1, '{150, 0, 0, 0}, 250, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_word", n_control, 16'h0001);
        chk("rst_wspike", n_wspike, 0);
        chk("rst_ready", ev_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spike_out", spike_out, 0);
        chk("rst_vmem_out", vmem_out, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_spike_cnt", spike_cnt, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("rel_word", n_control, 16'h0000);

        do_clear(0);
        for (int i = 0; i < 4; i++) begin
            wq = {};
            for (int j = 0; j < tbl[i].n; j++) wq.push_back(tbl[i].w[j]);
            run_step(0, i == 0);
            chk("tbl_vmem", vmem_out, 64'(tbl[i].vm));
            chk("tbl_spike", spike_out, tbl[i].sp);
        end

        repeat (6) begin
            wq = {};
            repeat ($urandom_range(1, 6)) wq.push_back(int'($urandom_range(0, 120)));
            run_step(1, 0);
        end

        do_clear(0);
        wq = {};
        repeat (256) wq.push_back(1);
        run_step(1, 0);
        chk("wrap_vmem", vmem_out, 256);
        chk("wrap_idle_word", n_control, 16'h0000);

        do_clear(1);

        start = 1;
        @(posedge clk); #1;
        start = 0;
        ev_valid = 1;
        ev_weight = 80;
        ev_last = 1;
        @(posedge clk); #1;
        ev_valid = 0;
        ev_last = 0;
        chk("drain_word", n_control, 16'h0102);
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_word", n_control, 16'h0001);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ev_ready, 0);
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        chk("post_rst_word", n_control, 16'h0000);
        chk("post_rst_v", nv, 0);
        chk("post_rst_steps", step_cnt, 0);

        wq = {90, 30};
        run_step(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
